// File: rtl/avl_bus_ram_slave_if.sv
// Avalon-MM bundle between a bus master and the RAM slave.
interface avl_bus_ram_slave_if;
    logic [31:0] avl_address;
    logic [3:0]  avl_byte_en;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_write_data;
    logic [31:0] avl_read_data;
    logic        avl_read_data_valid;
    logic        avl_waitrequest;

    modport slave (
        input  avl_address, avl_byte_en, avl_read, avl_write, avl_write_data,
        output avl_read_data, avl_read_data_valid, avl_waitrequest
    );

    modport master (
        output avl_address, avl_byte_en, avl_read, avl_write, avl_write_data,
        input  avl_read_data, avl_read_data_valid, avl_waitrequest
    );
endinterface

// File: rtl/avl_bus_ram_slave.sv
// Avalon-MM word RAM slave: byte-enabled writes, fixed-latency pipelined reads,
// optional per-command wait states and a cap on outstanding reads.
module avl_bus_ram_slave #(
    parameter int unsigned SIZE_WORDS   = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 2,
    parameter int unsigned WAIT_CYCLES  = 0
) (
    input logic                clk,
    input logic                rest,
    avl_bus_ram_slave_if.slave bus_io
);

    localparam int unsigned AW = $clog2(SIZE_WORDS);
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [PW-1:0]           pend_q, pend_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             data_q [READ_LATENCY];
    logic [31:0]             data_d [READ_LATENCY];
    logic [31:0]             mem_q  [SIZE_WORDS];

    logic          cmd, retire, pend_full, fsm_stall, wait_req;
    logic          accept, wr_acc, rd_acc;
    logic [AW-1:0] idx;
    logic          unused_addr;

    // Only the word index matters; everything above wraps, byte offset is ignored.
    assign idx         = bus_io.avl_address[AW+1:2];
    assign unused_addr = ^{bus_io.avl_address[31:AW+2], bus_io.avl_address[1:0]};

    assign cmd       = bus_io.avl_read | bus_io.avl_write;
    assign retire    = vld_q[READ_LATENCY-1];
    // A response leaving this cycle frees a slot, so the cap does not stall then.
    assign pend_full = (pend_q == PW'(MAX_PENDING)) && !retire;

    // Wait-state stall: every command sees WAIT_CYCLES stall cycles before acceptance.
    always_comb begin
        fsm_stall = 1'b0;
        if (WAIT_CYCLES != 0 && cmd) begin
            unique case (state_q)
                StIdle:  fsm_stall = 1'b1;
                StWait:  fsm_stall = (cnt_q != 4'd0);
                default: fsm_stall = 1'b0;
            endcase
        end
    end

    assign wait_req = pend_full | fsm_stall;
    assign accept   = cmd & ~wait_req;
    // Simultaneous read and write is a write only.
    assign wr_acc   = accept & bus_io.avl_write;
    assign rd_acc   = accept & bus_io.avl_read & ~bus_io.avl_write;

    // Wait-state FSM and its down-counter.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else if (WAIT_CYCLES != 0) begin
            unique case (state_q)
                StIdle: begin
                    if (cmd) begin
                        state_q <= StWait;
                        cnt_q   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                StWait: begin
                    if (!cmd) begin
                        // Master withdrew the command: abandon it without side effects.
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (accept) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Outstanding-read count: +1 on accept, -1 on retire.
    always_comb begin
        pend_d = pend_q;
        if (rd_acc && !retire) begin
            pend_d = pend_q + 1'b1;
        end else if (!rd_acc && retire) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Read shift pipeline; the word is captured at acceptance so later writes cannot leak in.
    always_comb begin
        vld_d[0]  = rd_acc;
        data_d[0] = rd_acc ? mem_q[idx] : 32'd0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Control state; reset drops any reads in flight.
    always_ff @(posedge clk) begin
        if (rest) begin
            pend_q <= '0;
            vld_q  <= '0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
        end
    end

    // Read data stages need no reset: the output is gated by the valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    // Storage array, byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_io.avl_byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= bus_io.avl_write_data[8*b +: 8];
                end
            end
        end
    end

    assign bus_io.avl_waitrequest     = wait_req;
    assign bus_io.avl_read_data_valid = retire;
    assign bus_io.avl_read_data       = retire ? data_q[READ_LATENCY-1] : 32'd0;

endmodule

// File: tb/tb_avl_bus_ram_slave.sv
// Self-checking bench for avl_bus_ram_slave: directed vector table, randomized traffic
// against a queue-based model, and hand sequences for throttling, wait states and reset.
module tb_avl_bus_ram_slave;

    logic clk = 1'b0;
    logic rest;
    always #5 clk = ~clk;

    avl_bus_ram_slave_if b0 ();
    avl_bus_ram_slave_if b1 ();
    avl_bus_ram_slave_if b2 ();

    avl_bus_ram_slave #(
        .SIZE_WORDS(1024), .READ_LATENCY(2), .MAX_PENDING(2), .WAIT_CYCLES(0)
    ) u_dut0 (.clk(clk), .rest(rest), .bus_io(b0));

    avl_bus_ram_slave #(
        .SIZE_WORDS(1024), .READ_LATENCY(4), .MAX_PENDING(2), .WAIT_CYCLES(0)
    ) u_dut1 (.clk(clk), .rest(rest), .bus_io(b1));

    avl_bus_ram_slave #(
        .SIZE_WORDS(1024), .READ_LATENCY(2), .MAX_PENDING(2), .WAIT_CYCLES(3)
    ) u_dut2 (.clk(clk), .rest(rest), .bus_io(b2));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          exp_vld;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    vec_t        vecs[$];
    rsp_t        exp_q[$];
    logic [31:0] ref_mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input bit ev,
                                input logic [31:0] ed, input string nm);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wd;
        v.exp_vld = ev; v.exp_data = ed; v.name = nm;
        return v;
    endfunction

    // One command on dut0, then watch six cycles for its response.
    task automatic run_vec(input vec_t v);
        int          stalls, nvld, vld_at;
        logic [31:0] vdata;
        bit          zero_ok;
        @(posedge clk); #1;
        b0.avl_read = v.rd; b0.avl_write = v.wr; b0.avl_address = v.addr;
        b0.avl_byte_en = v.be; b0.avl_write_data = v.wdata;
        stalls = 0;
        @(negedge clk);
        while (b0.avl_waitrequest && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        chk({v.name, " stalls"}, stalls, 0);
        @(posedge clk); #1;
        b0.avl_read = 1'b0; b0.avl_write = 1'b0;
        nvld = 0; vld_at = 0; vdata = 32'd0; zero_ok = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (b0.avl_read_data_valid) begin
                nvld++;
                if (vld_at == 0) begin
                    vld_at = k;
                    vdata  = b0.avl_read_data;
                end
            end else if (b0.avl_read_data !== 32'd0) begin
                zero_ok = 1'b0;
            end
        end
        chk({v.name, " valid_count"}, nvld, v.exp_vld ? 1 : 0);
        chk({v.name, " data_zero_when_idle"}, zero_ok, 1);
        if (v.exp_vld) begin
            chk({v.name, " latency"}, vld_at, 2);
            chk({v.name, " data"}, vdata, v.exp_data);
        end
    endtask

    // Command on dut2; returns how many stall cycles it saw before acceptance.
    task automatic b2_cmd(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int stalls);
        @(posedge clk); #1;
        b2.avl_read = rd; b2.avl_write = wr; b2.avl_address = addr;
        b2.avl_byte_en = 4'hF; b2.avl_write_data = wd;
        stalls = 0;
        @(negedge clk);
        while (b2.avl_waitrequest && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        b2.avl_read = 1'b0; b2.avl_write = 1'b0;
    endtask

    task automatic b2_obs(input int n, output int nvld, output int vld_at,
                          output logic [31:0] vdata);
        nvld = 0; vld_at = 0; vdata = 32'd0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (b2.avl_read_data_valid) begin
                nvld++;
                if (vld_at == 0) begin
                    vld_at = k;
                    vdata  = b2.avl_read_data;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stalls, nvld, vld_at, outs, max_outs;
        logic [31:0] vdata, d;
        bit          acc_hist [32];
        bit          stalled;
        bit          rd, wr;
        int          idx;
        logic [3:0]  be;
        logic [31:0] addr, wd;

        b0.avl_read = 0; b0.avl_write = 0; b0.avl_address = 0; b0.avl_byte_en = 0;
        b0.avl_write_data = 0;
        b1.avl_read = 0; b1.avl_write = 0; b1.avl_address = 0; b1.avl_byte_en = 0;
        b1.avl_write_data = 0;
        b2.avl_read = 0; b2.avl_write = 0; b2.avl_address = 0; b2.avl_byte_en = 0;
        b2.avl_write_data = 0;
        rest = 1'b1;
        repeat (3) @(posedge clk);
        #1 rest = 1'b0;
        @(negedge clk);
        chk("reset dut0 valid", b0.avl_read_data_valid, 0);
        chk("reset dut0 data", b0.avl_read_data, 0);
        chk("reset dut0 waitreq", b0.avl_waitrequest, 0);
        chk("reset dut1 valid", b1.avl_read_data_valid, 0);
        chk("reset dut1 waitreq", b1.avl_waitrequest, 0);
        chk("reset dut2 valid", b2.avl_read_data_valid, 0);
        chk("reset dut2 waitreq", b2.avl_waitrequest, 0);

        // Directed table on dut0.
        vecs.push_back(mk(0, 1, 32'h10, 4'hF, 32'h12345678, 0, 0, "wr_0x10"));
        vecs.push_back(mk(1, 0, 32'h10, 4'h0, 32'h0, 1, 32'h12345678, "rd_0x10"));
        vecs.push_back(mk(0, 1, 32'h20, 4'hF, 32'h00000000, 0, 0, "clr_0x20"));
        vecs.push_back(mk(0, 1, 32'h20, 4'h5, 32'hAABBCCDD, 0, 0, "wr_be5"));
        vecs.push_back(mk(1, 0, 32'h20, 4'hF, 32'h0, 1, 32'h00BB00DD, "rd_be5"));
        vecs.push_back(mk(0, 1, 32'h1000, 4'hF, 32'hCAFEF00D, 0, 0, "wr_wrap"));
        vecs.push_back(mk(1, 0, 32'h0, 4'h0, 32'h0, 1, 32'hCAFEF00D, "rd_wrap"));
        vecs.push_back(mk(0, 1, 32'h4, 4'hF, 32'h11111111, 0, 0, "wr_0x4"));
        vecs.push_back(mk(1, 1, 32'h4, 4'hF, 32'h22222222, 0, 0, "rdwr_0x4"));
        vecs.push_back(mk(1, 0, 32'h4, 4'h0, 32'h0, 1, 32'h22222222, "rd_after_rdwr"));
        vecs.push_back(mk(0, 1, 32'h8, 4'hF, 32'h5A5A5A5A, 0, 0, "wr_0x8"));
        vecs.push_back(mk(0, 1, 32'h8, 4'h0, 32'hFFFFFFFF, 0, 0, "wr_be0"));
        vecs.push_back(mk(1, 0, 32'h8, 4'h0, 32'h0, 1, 32'h5A5A5A5A, "rd_be0"));
        vecs.push_back(mk(1, 0, 32'hFFFF_F007, 4'h0, 32'h0, 1, 32'h22222222, "rd_hi_bits"));
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Preload the 16-word window used by the random phase.
        for (int i = 0; i < 16; i++) begin
            d = $urandom();
            ref_mem[i] = d;
            run_vec(mk(0, 1, 32'(i) << 2, 4'hF, d, 0, 0, "init_wr"));
        end

        // Randomized traffic on dut0 against a response-queue model.
        stalled = 1'b0; rd = 0; wr = 0; idx = 0; be = 0; addr = 0; wd = 0;
        for (int c = 0; c < 300; c++) begin
            bit exp_ret, exp_wait, cmd;
            @(posedge clk); #1;
            if (!stalled) begin
                if (c < 290) begin
                    int r = int'($urandom_range(0, 3));
                    rd   = (r == 1) || (r == 3);
                    wr   = (r >= 2);
                    idx  = int'($urandom_range(0, 15));
                    addr = ($urandom() & 32'hFFFF_F003) | (32'(idx) << 2);
                    be   = 4'($urandom());
                    wd   = $urandom();
                end else begin
                    rd = 1'b0; wr = 1'b0;
                end
                b0.avl_read = rd; b0.avl_write = wr; b0.avl_address = addr;
                b0.avl_byte_en = be; b0.avl_write_data = wd;
            end
            @(negedge clk);
            exp_ret  = (exp_q.size() > 0) && (exp_q[0].due == c);
            exp_wait = (exp_q.size() == 2) && !exp_ret;
            cmd      = rd | wr;
            chk("rand waitreq", b0.avl_waitrequest, exp_wait);
            chk("rand valid", b0.avl_read_data_valid, exp_ret);
            chk("rand data", b0.avl_read_data, exp_ret ? exp_q[0].data : 32'd0);
            if (exp_ret) void'(exp_q.pop_front());
            if (cmd && !exp_wait) begin
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                    end
                end else begin
                    rsp_t e;
                    e.due  = c + 2;
                    e.data = ref_mem[idx];
                    exp_q.push_back(e);
                end
            end
            stalled = cmd && exp_wait;
        end
        b0.avl_read = 1'b0; b0.avl_write = 1'b0;
        chk("rand drained", exp_q.size(), 0);

        // Throttling on dut1: continuous reads, latency 4, two outstanding.
        @(posedge clk); #1;
        b1.avl_read = 1'b1; b1.avl_address = 32'h0;
        outs = 0; max_outs = 0;
        for (int k = 0; k < 16; k++) begin
            bit exp_w;
            @(negedge clk);
            exp_w = (k % 4) >= 2;
            acc_hist[k] = !exp_w;
            chk("throttle waitreq", b1.avl_waitrequest, exp_w);
            chk("throttle valid", b1.avl_read_data_valid, (k >= 4) ? acc_hist[k-4] : 1'b0);
            if (b1.avl_read_data_valid) outs--;
            if (!b1.avl_waitrequest) outs++;
            if (outs > max_outs) max_outs = outs;
        end
        @(posedge clk); #1;
        b1.avl_read = 1'b0;
        chk("throttle max_outstanding_le2", max_outs <= 2, 1);
        repeat (6) @(posedge clk);

        // Wait states on dut2.
        b2_cmd(0, 1, 32'h40, 32'hDEADBEEF, stalls);
        chk("wait write stalls", stalls, 3);
        b2_cmd(1, 0, 32'h40, 32'h0, stalls);
        chk("wait read stalls", stalls, 3);
        b2_obs(5, nvld, vld_at, vdata);
        chk("wait read valid_count", nvld, 1);
        chk("wait read latency", vld_at, 2);
        chk("wait read data", vdata, 32'hDEADBEEF);
        // Withdrawn command: one stall cycle, then dropped.
        @(posedge clk); #1;
        b2.avl_read = 1'b1; b2.avl_address = 32'h40;
        @(negedge clk);
        chk("abort stall", b2.avl_waitrequest, 1);
        @(posedge clk); #1;
        b2.avl_read = 1'b0;
        @(negedge clk);
        chk("abort idle waitreq", b2.avl_waitrequest, 0);
        b2_obs(6, nvld, vld_at, vdata);
        chk("abort no valid", nvld, 0);
        b2_cmd(0, 1, 32'h44, 32'h0BADF00D, stalls);
        chk("after abort stalls", stalls, 3);

        // Reset one cycle after a read accept on dut0.
        @(posedge clk); #1;
        b0.avl_read = 1'b1; b0.avl_address = 32'h10;
        @(negedge clk);
        chk("rst read accepted", b0.avl_waitrequest, 0);
        @(posedge clk); #1;
        b0.avl_read = 1'b0; rest = 1'b1;
        nvld = 0;
        @(negedge clk);
        if (b0.avl_read_data_valid) nvld++;
        @(posedge clk); #1;
        rest = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b0.avl_read_data_valid) nvld++;
        end
        chk("rst discarded read", nvld, 0);
        run_vec(mk(1, 0, 32'h10, 4'h0, 32'h0, 1, ref_mem[4], "rd_after_reset"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
